// File: rtl/div_arb_pkg.sv
// Shared types and helpers for the shared-divider arbiter.
// Latency: none (types, constants and a combinational pick function).
// Backpressure: not applicable.
package div_arb_pkg;

  typedef enum logic [1:0] {IDLE, CALC, RESP} state_t;

  localparam int DEFAULT_WIDTH = 32;
  localparam logic [DEFAULT_WIDTH-1:0] DIV0 = '1;

  // First set bit of vld searching upward from ptr, wrapping at nreq (nreq <= 8).
  function automatic logic [2:0] rr_pick(input logic [2:0] ptr, input logic [7:0] vld,
                                         input int nreq);
    logic [2:0] pick;
    int idx;
    pick = ptr;
    for (int k = 7; k >= 0; k--) begin
      idx = int'(ptr) + k;
      if (idx >= nreq) idx = idx - nreq;
      if (k < nreq && vld[idx[2:0]]) pick = idx[2:0];
    end
    return pick;
  endfunction

endpackage

// File: rtl/div_iter_core.sv
// Radix-2 restoring divider, one quotient bit per clock, MSB first.
// Latency: WIDTH clocks after start; done pulses during the final step with next-state results.
// Backpressure: none; the caller must capture quotient/remainder while done is high.
module div_iter_core
  import div_arb_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder
);

  localparam int CW = $clog2(WIDTH + 1);

  logic             active;
  logic [CW-1:0]    step_cnt;
  logic [WIDTH-1:0] prem;
  logic [WIDTH-1:0] quo;
  logic [WIDTH-1:0] dvs;
  logic [WIDTH:0]   shifted;
  logic [WIDTH:0]   diff;
  logic             qbit;

  // quo shifts dividend bits out of the top while quotient bits enter at the bottom.
  always_comb begin
    shifted   = {prem, quo[WIDTH-1]};
    diff      = shifted - {1'b0, dvs};
    qbit      = ~diff[WIDTH];
    remainder = qbit ? diff[WIDTH-1:0] : shifted[WIDTH-1:0];
    quotient  = {quo[WIDTH-2:0], qbit};
  end

  assign done = active && (step_cnt == CW'(WIDTH - 1));

  always_ff @(posedge clk) begin
    if (reset) begin
      active   <= 1'b0;
      step_cnt <= '0;
    end else if (start) begin
      active   <= 1'b1;
      step_cnt <= '0;
    end else if (active) begin
      step_cnt <= step_cnt + CW'(1);
      if (done) active <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (start) begin
      prem <= '0;
      quo  <= dividend;
      dvs  <= divisor;
    end else if (active) begin
      prem <= remainder;
      quo  <= quotient;
    end
  end

endmodule

// File: rtl/div_share_arbiter.sv
// Round-robin sharing of one iterative divider among NREQ requesters.
// Latency: WIDTH+1 cycles accept-to-response (2 for a zero divisor).
// Backpressure: response held until rsp_ready of the granted requester; no accept while busy.
module div_share_arbiter
  import div_arb_pkg::*;
#(
  parameter int NREQ  = 4,
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [NREQ-1:0]       req_valid,
  output logic [NREQ-1:0]       req_ready,
  input  logic [NREQ*WIDTH-1:0] req_dividend,
  input  logic [NREQ*WIDTH-1:0] req_divisor,
  output logic [NREQ-1:0]       rsp_valid,
  input  logic [NREQ-1:0]       rsp_ready,
  output logic [WIDTH-1:0]      rsp_quotient,
  output logic [WIDTH-1:0]      rsp_remainder,
  output logic                  busy
);

  localparam logic [WIDTH-1:0] ALL_ONES = {WIDTH{DIV0[0]}};

  state_t           state, state_nxt;
  logic [2:0]       rr_ptr, grant, gnt_id;
  logic [WIDTH-1:0] sel_dividend, sel_divisor;
  logic [WIDTH-1:0] q_res, r_res, core_q, core_r;
  logic             any_vld, accept, div_zero, core_start, core_done, rsp_hs, div0_pend;

  assign any_vld    = |req_valid;
  assign grant      = rr_pick(rr_ptr, 8'(req_valid), NREQ);
  assign accept     = (state == IDLE) && any_vld && !reset;
  assign div_zero   = (sel_divisor == '0);
  assign core_start = accept && !div_zero;

  always_comb begin
    sel_dividend = '0;
    sel_divisor  = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (grant == 3'(i)) begin
        sel_dividend = req_dividend[i*WIDTH +: WIDTH];
        sel_divisor  = req_divisor[i*WIDTH +: WIDTH];
      end
    end
  end

  // A zero-divisor result is held back one cycle so it surfaces after the result load.
  assign req_ready     = accept ? (NREQ'(1) << grant) : '0;
  assign rsp_valid     = (state == RESP && !div0_pend) ? (NREQ'(1) << gnt_id) : '0;
  assign rsp_hs        = |(rsp_valid & rsp_ready);
  assign rsp_quotient  = q_res;
  assign rsp_remainder = r_res;
  assign busy          = (state != IDLE);

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (accept) state_nxt = div_zero ? RESP : CALC;
      CALC:    if (core_done) state_nxt = RESP;
      RESP:    if (rsp_hs) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      rr_ptr    <= '0;
      gnt_id    <= '0;
      q_res     <= '0;
      r_res     <= '0;
      div0_pend <= 1'b0;
    end else begin
      state <= state_nxt;
      if (accept) begin
        gnt_id    <= grant;
        rr_ptr    <= (grant == 3'(NREQ - 1)) ? 3'd0 : grant + 3'd1;
        div0_pend <= div_zero;
      end
      if (div0_pend) begin
        q_res     <= ALL_ONES;
        r_res     <= ALL_ONES;
        div0_pend <= 1'b0;
      end
      if (core_done) begin
        q_res <= core_q;
        r_res <= core_r;
      end
    end
  end

  div_iter_core #(.WIDTH(WIDTH)) u_core (
    .clk       (clk),
    .reset     (reset),
    .start     (core_start),
    .dividend  (sel_dividend),
    .divisor   (sel_divisor),
    .done      (core_done),
    .quotient  (core_q),
    .remainder (core_r)
  );

endmodule

// File: tb/tb_div_share_arbiter.sv
// Bench for div_share_arbiter: directed scenarios plus random traffic, all cycles
// checked against a transaction-level model (round-robin pick, / and %, response timestamps).
module tb_div_share_arbiter;

  localparam int N = 4;
  localparam int W = 32;

  logic           clk = 1'b0;
  logic           reset;
  logic [N-1:0]   req_valid, req_ready, rsp_valid, rsp_ready;
  logic [N*W-1:0] req_dividend, req_divisor;
  logic [W-1:0]   rsp_quotient, rsp_remainder;
  logic           busy;

  always #5 clk = ~clk;

  div_share_arbiter #(.NREQ(N), .WIDTH(W)) dut (
    .clk           (clk),
    .reset         (reset),
    .req_valid     (req_valid),
    .req_ready     (req_ready),
    .req_dividend  (req_dividend),
    .req_divisor   (req_divisor),
    .rsp_valid     (rsp_valid),
    .rsp_ready     (rsp_ready),
    .rsp_quotient  (rsp_quotient),
    .rsp_remainder (rsp_remainder),
    .busy          (busy)
  );

  int n_checks = 0;
  int n_err    = 0;
  bit chk_en   = 1'b0;

  // Transaction-level model: one job in flight, response valid from cycle m_t_rsp.
  bit           m_busy = 1'b0;
  int           m_id = 0, m_ptr = 0, m_cyc = 0, m_t_rsp = 0, g;
  logic [W-1:0] m_q, m_r, m_a, m_b;
  logic [N-1:0] exp_rdy, exp_rv, hs_req;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, want 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic int rr_search(input int ptr, input logic [N-1:0] v);
    for (int k = 0; k < N; k++) if (v[(ptr + k) % N]) return (ptr + k) % N;
    return 0;
  endfunction

  always @(negedge clk) begin
    if (chk_en) begin
      exp_rdy = '0;
      if (!reset && !m_busy && req_valid != '0) exp_rdy = N'(1) << rr_search(m_ptr, req_valid);
      exp_rv = (m_busy && m_cyc >= m_t_rsp) ? (N'(1) << m_id) : '0;
      chk("m_req_ready", 64'(req_ready), 64'(exp_rdy));
      chk("m_rsp_valid", 64'(rsp_valid), 64'(exp_rv));
      chk("m_busy", 64'(busy), 64'(m_busy));
      if (exp_rv != '0) begin
        chk("m_quotient", 64'(rsp_quotient), 64'(m_q));
        chk("m_remainder", 64'(rsp_remainder), 64'(m_r));
      end
      if (reset) begin
        m_busy = 1'b0;
        m_ptr  = 0;
      end else if (m_busy) begin
        if ((exp_rv & rsp_ready) != '0) m_busy = 1'b0;
      end else if (exp_rdy != '0) begin
        g     = rr_search(m_ptr, req_valid);
        m_a   = req_dividend[g*W +: W];
        m_b   = req_divisor[g*W +: W];
        m_id  = g;
        m_ptr = (g + 1) % N;
        if (m_b == '0) begin
          m_q = '1; m_r = '1; m_t_rsp = m_cyc + 2;
        end else begin
          m_q = m_a / m_b; m_r = m_a % m_b; m_t_rsp = m_cyc + W + 1;
        end
        m_busy = 1'b1;
      end
      m_cyc++;
    end
  end

  task automatic set_op(input int i, input logic [W-1:0] a, input logic [W-1:0] b);
    req_dividend[i*W +: W] = a;
    req_divisor[i*W +: W]  = b;
    req_valid[i]           = 1'b1;
  endtask

  // One cycle: sample handshakes mid-cycle, then drop accepted requests after the edge.
  task automatic step();
    @(negedge clk);
    hs_req = req_valid & req_ready;
    @(posedge clk);
    #1;
    req_valid = req_valid & ~hs_req;
  endtask

  task automatic drain();
    int k;
    k = 0;
    rsp_ready = '1;
    while ((busy || req_valid != '0) && k < 400) begin
      step();
      k++;
    end
    chk("drain_timeout", 64'(k < 400), 64'(1));
  endtask

  task automatic run_one(input int i, input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic [W-1:0] q, input logic [W-1:0] r, input int lat,
                         input string nm);
    int k;
    bit acc, got;
    rsp_ready = '1;
    set_op(i, a, b);
    acc = 1'b0;
    k   = 0;
    while (!acc && k < 80) begin
      step();
      acc = hs_req[i];
      k++;
    end
    chk({nm, "_accept"}, 64'(acc), 64'(1));
    got = 1'b0;
    k   = 0;
    while (!got && k < 80) begin
      @(negedge clk);
      k++;
      if (rsp_valid[i]) begin
        got = 1'b1;
        chk({nm, "_latency"}, 64'(k), 64'(lat + 1));
        chk({nm, "_q"}, 64'(rsp_quotient), 64'(q));
        chk({nm, "_r"}, 64'(rsp_remainder), 64'(r));
      end
      @(posedge clk);
      #1;
    end
    chk({nm, "_rsp_seen"}, 64'(got), 64'(1));
  endtask

  function automatic logic [2*W-1:0] rand_op();
    logic [W-1:0] a, b;
    a = $urandom;
    b = $urandom;
    case ($urandom_range(0, 3))
      0: b = '0;
      1: b = W'($urandom_range(1, 15));
      3: begin
        a = W'($urandom_range(0, 100));
        b = W'($urandom_range(101, 5000));
      end
      default: ;
    endcase
    return {a, b};
  endfunction

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout, want completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int k;
    bit rep, saw;
    int ord[$];
    int exp_ord[5];
    logic [2*W-1:0] op;
    exp_ord = '{0, 1, 2, 3, 0};

    reset        = 1'b1;
    req_valid    = '0;
    req_dividend = '0;
    req_divisor  = '0;
    rsp_ready    = '0;
    repeat (2) @(posedge clk);
    #1;
    chk_en = 1'b1;

    // All four valid while reset is high, then released together.
    set_op(0, 1000, 10); set_op(1, 77, 7); set_op(2, 5, 0); set_op(3, 9999, 100);
    rsp_ready = '1;
    @(negedge clk);
    chk("rst_req_ready", 64'(req_ready), 64'(0));
    chk("rst_rsp_valid", 64'(rsp_valid), 64'(0));
    chk("rst_quotient", 64'(rsp_quotient), 64'(0));
    chk("rst_remainder", 64'(rsp_remainder), 64'(0));
    chk("rst_busy", 64'(busy), 64'(0));
    @(posedge clk);
    #1;
    reset = 1'b0;

    rep = 1'b0;
    k   = 0;
    while (ord.size() < 5 && k < 400) begin
      step();
      for (int i = 0; i < N; i++) if (hs_req[i]) ord.push_back(i);
      if (hs_req[0] && !rep) begin
        set_op(0, 31, 4);
        rep = 1'b1;
      end
      k++;
    end
    chk("order_count", 64'(ord.size()), 64'(5));
    for (int j = 0; j < ord.size() && j < 5; j++) chk("order_from_reset", 64'(ord[j]), 64'(exp_ord[j]));
    drain();

    run_one(0, 17, 5, 3, 2, W, "d17_5");
    run_one(0, 7, 9, 0, 7, W, "d7_9");
    run_one(0, 32'hFFFF_FFFF, 1, 32'hFFFF_FFFF, 0, W, "dmax_1");
    run_one(2, 123, 0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1, "d123_0");

    // Response stall on requester 1 with requester 3 pending.
    rsp_ready = 4'b1101;
    set_op(1, 100, 7);
    k = 0;
    hs_req = '0;
    while (!hs_req[1] && k < 80) begin
      step();
      k++;
    end
    set_op(3, 50, 6);
    k = 0;
    while (!rsp_valid[1] && k < 80) begin
      @(negedge clk);
      k++;
    end
    chk("stall_rsp_seen", 64'(rsp_valid[1]), 64'(1));
    for (int j = 0; j < 5; j++) begin
      chk("stall_rsp_valid", 64'(rsp_valid), 64'(4'b0010));
      chk("stall_q", 64'(rsp_quotient), 64'(14));
      chk("stall_r", 64'(rsp_remainder), 64'(2));
      chk("stall_req_ready", 64'(req_ready), 64'(0));
      @(posedge clk);
      #1;
      if (j == 4) rsp_ready[1] = 1'b1;
      @(negedge clk);
    end
    @(posedge clk);
    #1;
    @(negedge clk);
    chk("after_hs_req_ready", 64'(req_ready), 64'(4'b1000));
    chk("after_hs_rsp_valid", 64'(rsp_valid), 64'(0));
    @(posedge clk);
    #1;
    req_valid[3] = 1'b0;
    drain();

    // Pointer at 2 with requesters 1 and 3 contending.
    run_one(1, 20, 4, 5, 0, W, "d20_4");
    set_op(1, 300, 7);
    set_op(3, 64, 8);
    ord.delete();
    k = 0;
    while (ord.size() < 2 && k < 200) begin
      step();
      for (int i = 0; i < N; i++) if (hs_req[i]) ord.push_back(i);
      k++;
    end
    chk("rr_count", 64'(ord.size()), 64'(2));
    if (ord.size() == 2) begin
      chk("rr_first", 64'(ord[0]), 64'(3));
      chk("rr_second", 64'(ord[1]), 64'(1));
    end
    drain();

    // Reset during the tenth divide step drops the operation.
    set_op(2, 1000, 3);
    k = 0;
    hs_req = '0;
    while (!hs_req[2] && k < 80) begin
      step();
      k++;
    end
    repeat (9) @(posedge clk);
    #1;
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    @(negedge clk);
    chk("midrst_rsp_valid", 64'(rsp_valid), 64'(0));
    chk("midrst_busy", 64'(busy), 64'(0));
    chk("midrst_q", 64'(rsp_quotient), 64'(0));
    chk("midrst_r", 64'(rsp_remainder), 64'(0));
    chk("midrst_req_ready", 64'(req_ready), 64'(0));
    saw = 1'b0;
    repeat (40) begin
      @(negedge clk);
      if (rsp_valid != '0) saw = 1'b1;
    end
    chk("midrst_no_rsp", 64'(saw), 64'(0));
    @(posedge clk);
    #1;
    set_op(0, 9, 3); set_op(1, 8, 2); set_op(2, 1000, 3); set_op(3, 4, 0);
    step();
    chk("midrst_ptr_zero", 64'(hs_req), 64'(4'b0001));
    drain();

    // Random traffic with random response backpressure.
    for (int c = 0; c < 1200; c++) begin
      for (int i = 0; i < N; i++) begin
        if (!req_valid[i] && $urandom_range(0, 9) < 2) begin
          op = rand_op();
          set_op(i, op[2*W-1:W], op[W-1:0]);
        end
      end
      rsp_ready = N'($urandom);
      step();
    end
    drain();

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
